// File: rtl/bmem_arbiter_if.sv
// Cache-side DFP ports and bmem port of the line arbiter, bundled for connection.
// slave is the arbiter's view; master is the view of the caches plus memory.
`timescale 1ns/1ps
interface bmem_arbiter_if #(
  parameter int unsigned LINE_BITS = 256,
  parameter int unsigned BEAT_BITS = 64
);
  logic [31:0]          icache_dfp_addr;
  logic                 icache_dfp_read;
  logic [LINE_BITS-1:0] icache_dfp_rdata;
  logic                 icache_dfp_resp;

  logic [31:0]          dcache_dfp_addr;
  logic                 dcache_dfp_read;
  logic                 dcache_dfp_write;
  logic [LINE_BITS-1:0] dcache_dfp_wdata;
  logic [LINE_BITS-1:0] dcache_dfp_rdata;
  logic                 dcache_dfp_resp;

  logic [31:0]          bmem_addr;
  logic                 bmem_read;
  logic                 bmem_write;
  logic [BEAT_BITS-1:0] bmem_wdata;
  logic                 bmem_ready;
  logic [31:0]          bmem_raddr;
  logic [BEAT_BITS-1:0] bmem_rdata;
  logic                 bmem_rvalid;

  modport slave (
    input  icache_dfp_addr, icache_dfp_read,
    input  dcache_dfp_addr, dcache_dfp_read, dcache_dfp_write, dcache_dfp_wdata,
    input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
    output icache_dfp_rdata, icache_dfp_resp,
    output dcache_dfp_rdata, dcache_dfp_resp,
    output bmem_addr, bmem_read, bmem_write, bmem_wdata
  );

  modport master (
    output icache_dfp_addr, icache_dfp_read,
    output dcache_dfp_addr, dcache_dfp_read, dcache_dfp_write, dcache_dfp_wdata,
    output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
    input  icache_dfp_rdata, icache_dfp_resp,
    input  dcache_dfp_rdata, dcache_dfp_resp,
    input  bmem_addr, bmem_read, bmem_write, bmem_wdata
  );
endinterface

// File: rtl/bmem_arbiter.sv
// Round-robin arbiter between I-cache and D-cache line ports and banked memory.
// One transaction at a time: reads gather BEATS beats into a line, writes serialize one.
`timescale 1ns/1ps
module bmem_arbiter #(
  parameter int unsigned LINE_BITS = 256,
  parameter int unsigned BEAT_BITS = 64
) (
  input  logic          clk,
  input  logic          rst,
  bmem_arbiter_if.slave bus
);
  localparam int unsigned BEATS = LINE_BITS / BEAT_BITS;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [31:0] ALIGN_MASK = ~32'(LINE_BITS / 8 - 1);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_BURST, RESP} state_t;
  typedef enum logic {ICACHE, DCACHE} client_t;

  state_t                          state_q, state_d;
  client_t                         grant_d, client_q, last_grant_q;
  logic [CNT_W-1:0]                beat_cnt_q;
  logic [31:0]                     addr_q, grant_addr;
  logic [BEATS-1:0][BEAT_BITS-1:0] wdata_q, line_q, line_d;
  logic [LINE_BITS-1:0]            ic_rdata_q, dc_rdata_q;
  logic                            ic_req, dc_req, any_req, grant_write;
  logic                            beat_store, beat_accept, is_last;
  logic                            unused_raddr;

  // Memory returns in order with a single read outstanding, so the tag is never needed.
  assign unused_raddr = ^bus.bmem_raddr;

  always_comb begin
    ic_req      = bus.icache_dfp_read;
    dc_req      = bus.dcache_dfp_read | bus.dcache_dfp_write;
    any_req     = ic_req | dc_req;
    grant_d     = ICACHE;
    if (ic_req && dc_req) begin
      grant_d = (last_grant_q == ICACHE) ? DCACHE : ICACHE;
    end else if (dc_req) begin
      grant_d = DCACHE;
    end
    // A simultaneous D-cache read and write is treated as a write.
    grant_write = (grant_d == DCACHE) && bus.dcache_dfp_write;
    grant_addr  = ((grant_d == ICACHE) ? bus.icache_dfp_addr : bus.dcache_dfp_addr) & ALIGN_MASK;
    beat_store  = (state_q == RD_WAIT) && bus.bmem_rvalid;
    beat_accept = (state_q == WR_BURST) && bus.bmem_ready;
    is_last     = (beat_cnt_q == LAST_BEAT);
    line_d      = line_q;
    if (beat_store) begin
      line_d[beat_cnt_q] = bus.bmem_rdata;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (any_req) state_d = grant_write ? WR_BURST : RD_REQ;
      RD_REQ:   if (bus.bmem_ready) state_d = RD_WAIT;
      RD_WAIT:  if (beat_store && is_last) state_d = RESP;
      WR_BURST: if (beat_accept && is_last) state_d = RESP;
      RESP:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      client_q     <= ICACHE;
      last_grant_q <= DCACHE;
      beat_cnt_q   <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      line_q       <= '0;
      ic_rdata_q   <= '0;
      dc_rdata_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            client_q     <= grant_d;
            last_grant_q <= grant_d;
            addr_q       <= grant_addr;
            wdata_q      <= bus.dcache_dfp_wdata;
            beat_cnt_q   <= '0;
          end
        end
        RD_REQ: begin
          if (bus.bmem_ready) beat_cnt_q <= '0;
        end
        RD_WAIT: begin
          if (beat_store) begin
            line_q     <= line_d;
            beat_cnt_q <= beat_cnt_q + 1'b1;
            // Publish the line when its last beat lands so rdata is valid during RESP.
            if (is_last) begin
              if (client_q == ICACHE) ic_rdata_q <= line_d;
              else                    dc_rdata_q <= line_d;
            end
          end
        end
        WR_BURST: begin
          if (beat_accept) beat_cnt_q <= beat_cnt_q + 1'b1;
        end
        RESP: begin
          beat_cnt_q <= '0;
        end
        default: beat_cnt_q <= '0;
      endcase
    end
  end

  always_comb begin
    bus.bmem_read        = (state_q == RD_REQ);
    bus.bmem_write       = (state_q == WR_BURST);
    bus.bmem_addr        = '0;
    bus.bmem_wdata       = '0;
    if ((state_q == RD_REQ) || (state_q == WR_BURST)) begin
      bus.bmem_addr = addr_q;
    end
    if (state_q == WR_BURST) begin
      bus.bmem_wdata = wdata_q[beat_cnt_q];
    end
    bus.icache_dfp_resp  = (state_q == RESP) && (client_q == ICACHE);
    bus.dcache_dfp_resp  = (state_q == RESP) && (client_q == DCACHE);
    bus.icache_dfp_rdata = ic_rdata_q;
    bus.dcache_dfp_rdata = dc_rdata_q;
  end
endmodule

// File: tb/tb_bmem_arbiter.sv
// Directed bench for bmem_arbiter: reads, writes, stalls, rvalid gaps, tie-break, mid-transaction reset.
`timescale 1ns/1ps
module tb_bmem_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  bmem_arbiter_if #(.LINE_BITS(256), .BEAT_BITS(64)) bus ();

  bmem_arbiter #(.LINE_BITS(256), .BEAT_BITS(64)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  function automatic logic [255:0] mk_line(input logic [15:0] b3, input logic [15:0] b2,
                                           input logic [15:0] b1, input logic [15:0] b0);
    return {{4{b3}}, {4{b2}}, {4{b1}}, {4{b0}}};
  endfunction

  // Drives one read for a client and acts as memory with latency 1; optionally holds the other client's read.
  task automatic do_read(input logic is_d, input logic [31:0] addr, input logic [255:0] line,
                         input int gap_after, input int gap_len, input logic also_other,
                         output int resp_cyc, output int nreads, output logic [31:0] rd_addr,
                         output logic [255:0] rdata, output int other_resp);
    int   sent;
    int   gap_left;
    logic accepted;
    resp_cyc = -1; nreads = 0; rd_addr = '0; rdata = '0; other_resp = 0;
    sent = 0; gap_left = gap_len; accepted = 1'b0;
    @(negedge clk);
    if (is_d) begin
      bus.dcache_dfp_addr = addr; bus.dcache_dfp_read = 1'b1; bus.dcache_dfp_write = 1'b0;
      if (also_other) bus.icache_dfp_read = 1'b1;
    end else begin
      bus.icache_dfp_addr = addr; bus.icache_dfp_read = 1'b1;
      if (also_other) bus.dcache_dfp_read = 1'b1;
    end
    for (int cyc = 1; cyc <= 40 && resp_cyc < 0; cyc++) begin
      @(negedge clk);
      bus.bmem_rvalid = 1'b0;
      if (bus.bmem_read) begin nreads++; rd_addr = bus.bmem_addr; end
      if (is_d ? bus.dcache_dfp_resp : bus.icache_dfp_resp) begin
        resp_cyc = cyc;
        rdata = is_d ? bus.dcache_dfp_rdata : bus.icache_dfp_rdata;
        if (is_d) bus.dcache_dfp_read = 1'b0; else bus.icache_dfp_read = 1'b0;
      end
      if (is_d ? bus.icache_dfp_resp : bus.dcache_dfp_resp) other_resp++;
      if (accepted && sent < 4 && resp_cyc < 0) begin
        if (sent == gap_after && gap_left > 0) begin
          gap_left--;
        end else begin
          bus.bmem_rvalid = 1'b1;
          bus.bmem_rdata  = line[64*sent +: 64];
          sent++;
        end
      end
      if (bus.bmem_read && bus.bmem_ready) accepted = 1'b1;
    end
    if (resp_cyc < 0) begin
      if (is_d) bus.dcache_dfp_read = 1'b0; else bus.icache_dfp_read = 1'b0;
    end
    bus.bmem_rvalid = 1'b0;
  endtask

  // Drives one D-cache write and acts as memory, withholding ready stall_len times on beat stall_beat.
  task automatic do_write(input logic [31:0] addr, input logic [255:0] line,
                          input int stall_beat, input int stall_len,
                          output int resp_cyc, output int nwrite, output int accepted,
                          output logic [255:0] got, output int beat1_cycles,
                          output int bad_addr, output int other_resp);
    int stalls;
    resp_cyc = -1; nwrite = 0; accepted = 0; got = '0; beat1_cycles = 0;
    bad_addr = 0; other_resp = 0; stalls = 0;
    @(negedge clk);
    bus.dcache_dfp_addr = addr; bus.dcache_dfp_wdata = line;
    bus.dcache_dfp_write = 1'b1; bus.dcache_dfp_read = 1'b0;
    for (int cyc = 1; cyc <= 40 && resp_cyc < 0; cyc++) begin
      @(negedge clk);
      bus.bmem_ready = 1'b1;
      if (bus.bmem_write) begin
        nwrite++;
        if (bus.bmem_addr !== addr) bad_addr++;
        if (bus.bmem_wdata === line[127:64]) beat1_cycles++;
        if (accepted == stall_beat && stalls < stall_len) begin
          bus.bmem_ready = 1'b0;
          stalls++;
        end else if (accepted < 4) begin
          got[64*accepted +: 64] = bus.bmem_wdata;
          accepted++;
        end
      end
      if (bus.dcache_dfp_resp) begin resp_cyc = cyc; bus.dcache_dfp_write = 1'b0; end
      if (bus.icache_dfp_resp) other_resp++;
    end
    bus.dcache_dfp_write = 1'b0;
    bus.bmem_ready = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    vectors++; if (bus.bmem_read !== 1'b0) begin miscompares++; $display("FAIL reset_bmem_read got=%h exp=0", bus.bmem_read); end
    vectors++; if (bus.bmem_write !== 1'b0) begin miscompares++; $display("FAIL reset_bmem_write got=%h exp=0", bus.bmem_write); end
    vectors++; if (bus.bmem_addr !== 32'h0) begin miscompares++; $display("FAIL reset_bmem_addr got=%h exp=0", bus.bmem_addr); end
    vectors++; if (bus.bmem_wdata !== 64'h0) begin miscompares++; $display("FAIL reset_bmem_wdata got=%h exp=0", bus.bmem_wdata); end
    vectors++; if (bus.icache_dfp_resp !== 1'b0) begin miscompares++; $display("FAIL reset_icache_resp got=%h exp=0", bus.icache_dfp_resp); end
    vectors++; if (bus.dcache_dfp_resp !== 1'b0) begin miscompares++; $display("FAIL reset_dcache_resp got=%h exp=0", bus.dcache_dfp_resp); end
    vectors++; if (bus.icache_dfp_rdata !== 256'h0) begin miscompares++; $display("FAIL reset_icache_rdata got=%h exp=0", bus.icache_dfp_rdata); end
    vectors++; if (bus.dcache_dfp_rdata !== 256'h0) begin miscompares++; $display("FAIL reset_dcache_rdata got=%h exp=0", bus.dcache_dfp_rdata); end
    rst = 1'b0;
  endtask

  task automatic test_tie();
    int r, n, o;
    logic [31:0] a;
    logic [255:0] d;
    logic [255:0] l1, l2, l3, l4;
    l1 = mk_line(16'h1a1a, 16'h1b1b, 16'h1c1c, 16'h1d1d);
    l2 = mk_line(16'h2a2a, 16'h2b2b, 16'h2c2c, 16'h2d2d);
    l3 = mk_line(16'h3a3a, 16'h3b3b, 16'h3c3c, 16'h3d3d);
    l4 = mk_line(16'h4a4a, 16'h4b4b, 16'h4c4c, 16'h4d4d);
    bus.dcache_dfp_addr = 32'h0000_5000;
    do_read(1'b0, 32'h0000_1100, l1, 0, 0, 1'b1, r, n, a, d, o);
    vectors++; if (r !== 6) begin miscompares++; $display("FAIL tie1_icache_resp_cycle got=%0d exp=6", r); end
    vectors++; if (a !== 32'h0000_1100) begin miscompares++; $display("FAIL tie1_addr got=%h exp=00001100", a); end
    vectors++; if (d !== l1) begin miscompares++; $display("FAIL tie1_rdata got=%h exp=%h", d, l1); end
    vectors++; if (o !== 0) begin miscompares++; $display("FAIL tie1_dcache_resp got=%0d exp=0", o); end
    do_read(1'b1, 32'h0000_5000, l2, 0, 0, 1'b0, r, n, a, d, o);
    vectors++; if (r !== 6) begin miscompares++; $display("FAIL tie1_dcache_resp_cycle got=%0d exp=6", r); end
    vectors++; if (a !== 32'h0000_5000) begin miscompares++; $display("FAIL tie1_dcache_addr got=%h exp=00005000", a); end
    vectors++; if (d !== l2) begin miscompares++; $display("FAIL tie1_dcache_rdata got=%h exp=%h", d, l2); end
    bus.dcache_dfp_addr = 32'h0000_5100;
    do_read(1'b0, 32'h0000_1200, l3, 0, 0, 1'b1, r, n, a, d, o);
    vectors++; if (r !== 6) begin miscompares++; $display("FAIL tie2_icache_resp_cycle got=%0d exp=6", r); end
    vectors++; if (a !== 32'h0000_1200) begin miscompares++; $display("FAIL tie2_addr got=%h exp=00001200", a); end
    vectors++; if (o !== 0) begin miscompares++; $display("FAIL tie2_dcache_resp got=%0d exp=0", o); end
    do_read(1'b1, 32'h0000_5100, l4, 0, 0, 1'b0, r, n, a, d, o);
    vectors++; if (d !== l4) begin miscompares++; $display("FAIL tie2_dcache_rdata got=%h exp=%h", d, l4); end
  endtask

  task automatic test_icache_read();
    int r, n, o;
    logic [31:0] a;
    logic [255:0] d, l;
    l = mk_line(16'hdddd, 16'hcccc, 16'hbbbb, 16'haaaa);
    do_read(1'b0, 32'h0000_1004, l, 0, 0, 1'b0, r, n, a, d, o);
    vectors++; if (r !== 6) begin miscompares++; $display("FAIL iread_resp_cycle got=%0d exp=6", r); end
    vectors++; if (n !== 1) begin miscompares++; $display("FAIL iread_bmem_read_cycles got=%0d exp=1", n); end
    vectors++; if (a !== 32'h0000_1000) begin miscompares++; $display("FAIL iread_addr got=%h exp=00001000", a); end
    vectors++; if (d !== l) begin miscompares++; $display("FAIL iread_rdata got=%h exp=%h", d, l); end
    vectors++; if (o !== 0) begin miscompares++; $display("FAIL iread_dcache_resp got=%0d exp=0", o); end
    @(negedge clk);
    vectors++; if (bus.icache_dfp_resp !== 1'b0) begin miscompares++; $display("FAIL iread_resp_pulse got=%h exp=0", bus.icache_dfp_resp); end
    vectors++; if (bus.icache_dfp_rdata !== l) begin miscompares++; $display("FAIL iread_rdata_hold got=%h exp=%h", bus.icache_dfp_rdata, l); end
  endtask

  task automatic test_dcache_write();
    int r, nw, acc, b1, bad, o;
    logic [255:0] g, l, prev;
    l = mk_line(16'h8888, 16'h7777, 16'h6666, 16'h5555);
    prev = mk_line(16'h4a4a, 16'h4b4b, 16'h4c4c, 16'h4d4d);
    do_write(32'h0000_2000, l, 0, 0, r, nw, acc, g, b1, bad, o);
    vectors++; if (r !== 5) begin miscompares++; $display("FAIL write_resp_cycle got=%0d exp=5", r); end
    vectors++; if (nw !== 4) begin miscompares++; $display("FAIL write_high_cycles got=%0d exp=4", nw); end
    vectors++; if (g !== l) begin miscompares++; $display("FAIL write_beats got=%h exp=%h", g, l); end
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL write_addr_errors got=%0d exp=0", bad); end
    vectors++; if (o !== 0) begin miscompares++; $display("FAIL write_icache_resp got=%0d exp=0", o); end
    vectors++; if (bus.dcache_dfp_rdata !== prev) begin miscompares++; $display("FAIL write_rdata_hold got=%h exp=%h", bus.dcache_dfp_rdata, prev); end
  endtask

  task automatic test_write_stall();
    int r, nw, acc, b1, bad, o;
    logic [255:0] g, l;
    l = mk_line(16'h8888, 16'h7777, 16'h6666, 16'h5555);
    do_write(32'h0000_2040, l, 1, 2, r, nw, acc, g, b1, bad, o);
    vectors++; if (r !== 7) begin miscompares++; $display("FAIL stall_resp_cycle got=%0d exp=7", r); end
    vectors++; if (b1 !== 3) begin miscompares++; $display("FAIL stall_beat1_cycles got=%0d exp=3", b1); end
    vectors++; if (acc !== 4) begin miscompares++; $display("FAIL stall_accepted got=%0d exp=4", acc); end
    vectors++; if (nw !== 6) begin miscompares++; $display("FAIL stall_high_cycles got=%0d exp=6", nw); end
    vectors++; if (g !== l) begin miscompares++; $display("FAIL stall_beats got=%h exp=%h", g, l); end
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL stall_addr_errors got=%0d exp=0", bad); end
  endtask

  task automatic test_read_gap();
    int r, n, o;
    logic [31:0] a;
    logic [255:0] d, l, iprev;
    l = mk_line(16'h4444, 16'h3333, 16'h2222, 16'h1111);
    iprev = mk_line(16'hdddd, 16'hcccc, 16'hbbbb, 16'haaaa);
    do_read(1'b1, 32'h0000_403c, l, 2, 3, 1'b0, r, n, a, d, o);
    vectors++; if (r !== 9) begin miscompares++; $display("FAIL gap_resp_cycle got=%0d exp=9", r); end
    vectors++; if (a !== 32'h0000_4020) begin miscompares++; $display("FAIL gap_addr got=%h exp=00004020", a); end
    vectors++; if (d !== l) begin miscompares++; $display("FAIL gap_rdata got=%h exp=%h", d, l); end
    vectors++; if (o !== 0) begin miscompares++; $display("FAIL gap_icache_resp got=%0d exp=0", o); end
    vectors++; if (bus.icache_dfp_rdata !== iprev) begin miscompares++; $display("FAIL gap_icache_rdata_hold got=%h exp=%h", bus.icache_dfp_rdata, iprev); end
  endtask

  task automatic test_reset_mid();
    int r, n, o, resps, reads;
    logic [31:0] a;
    logic [255:0] d, l;
    l = mk_line(16'h9d9d, 16'h9c9c, 16'h9b9b, 16'h9a9a);
    @(negedge clk);
    bus.icache_dfp_addr = 32'h0000_3000; bus.icache_dfp_read = 1'b1;
    @(negedge clk);
    vectors++; if (bus.bmem_read !== 1'b1) begin miscompares++; $display("FAIL rstmid_bmem_read got=%h exp=1", bus.bmem_read); end
    @(negedge clk);
    bus.bmem_rvalid = 1'b1; bus.bmem_rdata = l[63:0];
    @(negedge clk);
    bus.bmem_rdata = l[127:64];
    rst = 1'b1;
    #1;
    vectors++; if (bus.bmem_addr !== 32'h0) begin miscompares++; $display("FAIL rstmid_bmem_addr got=%h exp=0", bus.bmem_addr); end
    vectors++; if (bus.icache_dfp_resp !== 1'b0) begin miscompares++; $display("FAIL rstmid_icache_resp got=%h exp=0", bus.icache_dfp_resp); end
    vectors++; if (bus.icache_dfp_rdata !== 256'h0) begin miscompares++; $display("FAIL rstmid_icache_rdata got=%h exp=0", bus.icache_dfp_rdata); end
    vectors++; if (bus.dcache_dfp_rdata !== 256'h0) begin miscompares++; $display("FAIL rstmid_dcache_rdata got=%h exp=0", bus.dcache_dfp_rdata); end
    bus.icache_dfp_read = 1'b0; bus.bmem_rvalid = 1'b0;
    resps = 0; reads = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) rst = 1'b0;
      if (bus.icache_dfp_resp || bus.dcache_dfp_resp) resps++;
      if (bus.bmem_read || bus.bmem_write) reads++;
    end
    vectors++; if (resps !== 0) begin miscompares++; $display("FAIL rstmid_resp_after got=%0d exp=0", resps); end
    vectors++; if (reads !== 0) begin miscompares++; $display("FAIL rstmid_bmem_activity got=%0d exp=0", reads); end
    do_read(1'b0, 32'h0000_3000, l, 0, 0, 1'b0, r, n, a, d, o);
    vectors++; if (r !== 6) begin miscompares++; $display("FAIL rstmid_fresh_resp_cycle got=%0d exp=6", r); end
    vectors++; if (d !== l) begin miscompares++; $display("FAIL rstmid_fresh_rdata got=%h exp=%h", d, l); end
    vectors++; if (n !== 1) begin miscompares++; $display("FAIL rstmid_fresh_reads got=%0d exp=1", n); end
  endtask

  initial begin
    rst = 1'b1;
    bus.icache_dfp_addr = '0; bus.icache_dfp_read = 1'b0;
    bus.dcache_dfp_addr = '0; bus.dcache_dfp_read = 1'b0; bus.dcache_dfp_write = 1'b0;
    bus.dcache_dfp_wdata = '0;
    bus.bmem_ready = 1'b1; bus.bmem_raddr = '0; bus.bmem_rdata = '0; bus.bmem_rvalid = 1'b0;
    test_reset();
    test_tie();
    test_icache_read();
    test_dcache_write();
    test_write_stall();
    test_read_gap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
